rr_mux_sel_ctrl: RTL

- Two-channel round-robin select controller with a registered output stage.
- Sits directly upstream of the 2:1 data mux: arbitrates two valid/ready sources, drives the mux select `s`, and registers the selected data for the downstream consumer.
- Holds the grant for up to BURST accepted beats, then rotates so neither channel starves.

---
 rtl/rr_mux_sel_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rr_mux_sel_ctrl.sv
// Two-channel round-robin select controller for a 2:1 data mux.
// Grants one valid/ready source for up to BURST beats and registers the selected data.
module rr_mux_sel_ctrl #(
  parameter int WIDTH = 1,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic             v0,
  output logic             r0,
  input  logic [WIDTH-1:0] d1,
  input  logic             v1,
  output logic             r1,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             busy
);

  localparam int               CNT_W     = 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_s;
  logic [WIDTH-1:0] r_y;
  logic             r_y_valid;

  logic             w_free;
  logic             w_granted;
  logic             w_cur;
  logic             w_cur_v;
  logic             w_oth_v;
  logic             w_xfer;
  logic             w_burst_end;
  logic             w_release;
  logic [WIDTH-1:0] w_xdata;

  // The output register can take a new beat when empty or being drained this cycle.
  assign w_free      = !r_y_valid || y_ready;
  assign w_granted   = (r_state != IDLE);
  assign w_cur       = (r_state == GRANT1);
  assign w_cur_v     = w_cur ? v1 : v0;
  assign w_oth_v     = w_cur ? v0 : v1;
  assign w_xfer      = w_granted && w_cur_v && w_free;
  assign w_burst_end = w_xfer && (r_count == LAST_BEAT);
  // A grant ends on its final beat or as soon as the owner drops valid.
  assign w_release   = w_granted && (w_burst_end || !w_cur_v);
  assign w_xdata     = w_cur ? d1 : d0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_count <= '0;
      r_s     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_count <= w_count_nxt;
      r_s     <= (w_state_nxt == GRANT1);
    end
  end

  // Next-state and arbitration
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_count_nxt = r_count;
    unique case (r_state)
      IDLE: begin
        w_count_nxt = '0;
        if (v0 && v1) begin
          w_state_nxt = r_last ? GRANT0 : GRANT1;
        end else if (v0) begin
          w_state_nxt = GRANT0;
        end else if (v1) begin
          w_state_nxt = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (w_release) begin
          w_last_nxt  = w_cur;
          w_count_nxt = '0;
          if (w_oth_v) begin
            w_state_nxt = w_cur ? GRANT0 : GRANT1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_xfer) begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    r0   = 1'b0;
    r1   = 1'b0;
    busy = 1'b0;
    unique case (r_state)
      GRANT0: begin
        r0   = w_free;
        busy = 1'b1;
      end
      GRANT1: begin
        r1   = w_free;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered output stage; a drain and a new transfer may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else if (w_xfer) begin
      r_y       <= w_xdata;
      r_y_valid <= 1'b1;
    end else if (y_ready) begin
      r_y_valid <= 1'b0;
    end
  end

  assign s       = r_s;
  assign y       = r_y;
  assign y_valid = r_y_valid;

`ifndef SYNTHESIS
  a_ready_excl: assert property (@(posedge clk) disable iff (!rst_n) !(r0 && r1));
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    r_count < CNT_W'(BURST));
  a_sel_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
    s == (r_state == GRANT1));
`endif

endmodule
